// File: rtl/dram_lsu_pkg.sv
// Shared encodings for the dram_lsu load/store unit: access sizes, FSM states and
// the word-address slice position.
package dram_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Byte address bit where the memory word address begins
    localparam int WA_LSB = 2;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        DATA,
        WR,
        RESP
    } state_t;

endpackage

// File: rtl/dram_lsu_align.sv
// Little-endian lane handling for dram_lsu: load extract with sign/zero extension
// and store merge into the word read back from memory. Lanes assume a 32-bit word.
module dram_lsu_align
    import dram_lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       size,
    input  logic             is_unsigned,
    input  logic [1:0]       lane,
    input  logic [WIDTH-1:0] rdata,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] ld_data,
    output logic [WIDTH-1:0] st_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
        ld_data  = rdata;
        st_data  = rdata;
        case (lane)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        case (size)
            SZ_BYTE: begin
                ld_data = {{(WIDTH-8){~is_unsigned & byte_sel[7]}}, byte_sel};
                case (lane)
                    2'd1:    st_data[15:8]  = wdata[7:0];
                    2'd2:    st_data[23:16] = wdata[7:0];
                    2'd3:    st_data[31:24] = wdata[7:0];
                    default: st_data[7:0]   = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                ld_data = {{(WIDTH-16){~is_unsigned & half_sel[15]}}, half_sel};
                if (lane[1]) st_data[31:16] = wdata[15:0];
                else         st_data[15:0]  = wdata[15:0];
            end
            default: begin
                ld_data = rdata;
                st_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/dram_lsu.sv
// Load/store unit in front of the word-wide data memory: RMW for sub-word stores,
// extension for loads. Define MISALIGN_TRAP_EN to report misaligned requests via resp_err.
module dram_lsu
    import dram_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [WIDTH-1:0]      req_wdata,
    output logic                  resp_valid,
    output logic [WIDTH-1:0]      resp_rdata,
    output logic                  resp_err,
    output logic                  dram_we_o,
    output logic [ADDR_WIDTH-1:0] dram_addr_o,
    output logic [WIDTH-1:0]      dram_din_o,
    input  logic [WIDTH-1:0]      dram_dout_i
);

    state_t                state, state_nx;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [1:0]            size_q;
    logic                  we_q, uns_q;
    logic [WIDTH-1:0]      wbuf_q, rdata_q;
    logic [WIDTH-1:0]      ld_data, st_data;
    logic                  accept, req_mis;
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];
    assign accept         = req_valid && req_ready;

`ifdef MISALIGN_TRAP_EN
    logic err_q;
    assign req_mis  = ((req_size == SZ_HALF) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
    assign resp_err = resp_valid && err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      err_q <= 1'b0;
        else if (accept) err_q <= req_mis;
    end
`else
    assign req_mis  = 1'b0;
    assign resp_err = 1'b0;
`endif

    dram_lsu_align #(.WIDTH(WIDTH)) u_align (
        .size        (size_q),
        .is_unsigned (uns_q),
        .lane        (addr_q[1:0]),
        .rdata       (dram_dout_i),
        .wdata       (wbuf_q),
        .ld_data     (ld_data),
        .st_data     (st_data)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept)
                      state_nx = req_mis ? RESP : (req_we && req_size[1]) ? WR : RD;
            RD:   state_nx = DATA;
            DATA: state_nx = we_q ? WR : RESP;
            WR:   state_nx = RESP;
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // wbuf_q starts as the raw store data; sub-word stores overwrite it with the merge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            size_q  <= SZ_BYTE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            wbuf_q  <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                addr_q  <= req_addr[ADDR_WIDTH+1:0];
                size_q  <= req_size;
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                wbuf_q  <= req_wdata;
                rdata_q <= '0;
            end else if (state == DATA) begin
                if (we_q) wbuf_q  <= st_data;
                else      rdata_q <= ld_data;
            end
        end
    end

    assign req_ready   = (state == IDLE);
    assign resp_valid  = (state == RESP);
    assign resp_rdata  = rdata_q;
    assign dram_we_o   = (state == WR);
    assign dram_addr_o = addr_q[ADDR_WIDTH+1:WA_LSB];
    assign dram_din_o  = wbuf_q;

endmodule

// File: tb/tb_dram_lsu.sv
// Scoreboard bench for dram_lsu: directed requests push expected responses and
// writes; a negedge monitor pops and compares data, error flag and latency.
module tb_dram_lsu;
    import dram_lsu_pkg::*;

    localparam int AW = 12;
    localparam int W  = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic [31:0]   req_addr = '0;
    logic [W-1:0]  req_wdata = '0;
    logic          req_ready, resp_valid, resp_err, dram_we_o;
    logic [W-1:0]  resp_rdata, dram_din_o, dram_dout_i;
    logic [AW-1:0] dram_addr_o;

    always #5 clk = ~clk;

    dram_lsu #(.ADDR_WIDTH(AW), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .dram_we_o(dram_we_o), .dram_addr_o(dram_addr_o),
        .dram_din_o(dram_din_o), .dram_dout_i(dram_dout_i)
    );

    logic [W-1:0] mem [0:(1<<AW)-1];
    initial for (int i = 0; i < (1<<AW); i++) mem[i] = '0;

    always @(posedge clk) begin
        if (dram_we_o) mem[dram_addr_o] <= dram_din_o;
        dram_dout_i <= mem[dram_addr_o];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { string nm; logic [31:0] rdata; logic err; int acc; int lat; } resp_t;
    typedef struct { string nm; logic [AW-1:0] addr; logic [31:0] data; int acc; int lat; } wr_t;
    resp_t rq[$];
    wr_t   wq[$];
    int checks = 0, fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        fails++;
        $display("FAIL %s", nm);
    endtask

    // Monitor: latency counted as cycles after the accept edge
    always @(negedge clk) begin
        resp_t r;
        wr_t   w;
        if (resp_valid) begin
            if (rq.size() == 0) fail_now("unexpected resp_valid");
            else begin
                r = rq.pop_front();
                chk({r.nm, " rdata"}, resp_rdata, r.rdata);
                chk({r.nm, " err"}, {31'd0, resp_err}, {31'd0, r.err});
                chk({r.nm, " resp latency"}, cyc - r.acc + 1, r.lat);
            end
        end
        if (dram_we_o) begin
            if (wq.size() == 0) fail_now("unexpected dram_we_o");
            else begin
                w = wq.pop_front();
                chk({w.nm, " wr addr"}, {20'd0, dram_addr_o}, {20'd0, w.addr});
                chk({w.nm, " wr data"}, dram_din_o, w.data);
                chk({w.nm, " wr latency"}, cyc - w.acc + 1, w.lat);
            end
        end
    end

    task automatic drive_accept(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd,
                                output int acc, output bit ok);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        ok = 1'b0;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            fail_now("accept timeout");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 acc = cyc;
    endtask

    task automatic ld(input string nm, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] exp, output int acc);
        bit ok;
        drive_accept(1'b0, sz, uns, a, 32'h0, acc, ok);
        if (ok) rq.push_back('{nm, exp, 1'b0, acc, 3});
    endtask

    task automatic st(input string nm, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] merged, output int acc);
        bit ok;
        bit word;
        word = sz[1];
        drive_accept(1'b1, sz, 1'b0, a, wd, acc, ok);
        if (ok) begin
            wq.push_back('{nm, a[AW+1:2], merged, acc, word ? 1 : 3});
            rq.push_back('{nm, 32'h0, 1'b0, acc, word ? 2 : 4});
        end
    endtask

`ifdef MISALIGN_TRAP_EN
    task automatic mis(input string nm, input logic we, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
        bit ok;
        int acc;
        drive_accept(we, sz, 1'b0, a, wd, acc, ok);
        if (ok) rq.push_back('{nm, 32'h0, 1'b1, acc, 1});
    endtask
`endif

    task automatic wait_idle();
        bit done;
        @(negedge clk);
        req_valid = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rq.size() == 0 && wq.size() == 0) begin done = 1'b1; break; end
            @(negedge clk);
        end
        if (!done) begin
            fail_now("drain timeout");
            rq.delete();
            wq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int a1, a2;
        bit ok;
        repeat (2) @(negedge clk);
        chk("reset req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("reset resp_err", {31'd0, resp_err}, 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'h0);
        chk("reset dram_we_o", {31'd0, dram_we_o}, 32'd0);
        chk("reset dram_addr_o", {20'd0, dram_addr_o}, 32'h0);
        chk("reset dram_din_o", dram_din_o, 32'h0);
        rst_n = 1'b1;

        st("st word 40", SZ_WORD, 32'h40, 32'hDEADBEEF, 32'hDEADBEEF, a1);
        ld("ld word 40", SZ_WORD, 1'b0, 32'h40, 32'hDEADBEEF, a1);

        st("st word 40b", SZ_WORD, 32'h40, 32'h11223344, 32'h11223344, a1);
        st("st byte 41", SZ_BYTE, 32'h41, 32'h000000AA, 32'h1122AA44, a1);
        ld("ld sbyte 41", SZ_BYTE, 1'b0, 32'h41, 32'hFFFFFFAA, a1);
        ld("ld ubyte 41", SZ_BYTE, 1'b1, 32'h41, 32'h000000AA, a1);
        ld("ld word 40 rmw", SZ_WORD, 1'b0, 32'h40, 32'h1122AA44, a1);

        st("st word 50", SZ_WORD, 32'h50, 32'h80017FFF, 32'h80017FFF, a1);
        ld("ld shalf 52", SZ_HALF, 1'b0, 32'h52, 32'hFFFF8001, a1);
        ld("ld shalf 50", SZ_HALF, 1'b0, 32'h50, 32'h00007FFF, a1);
        ld("ld uhalf 52", SZ_HALF, 1'b1, 32'h52, 32'h00008001, a1);
        ld("ld sbyte 53", SZ_BYTE, 1'b0, 32'h53, 32'hFFFFFF80, a1);
        st("st half 52", SZ_HALF, 32'h52, 32'h0000BEEF, 32'hBEEF7FFF, a1);
        ld("ld word 50 rmw", SZ_WORD, 1'b0, 32'h50, 32'hBEEF7FFF, a1);

        ld("ld size3 40", 2'b11, 1'b0, 32'h40, 32'h1122AA44, a1);
        ld("ld wrap 4040", SZ_WORD, 1'b0, 32'h4040, 32'h1122AA44, a1);

`ifdef MISALIGN_TRAP_EN
        mis("mis ld word 42", 1'b0, SZ_WORD, 32'h42, 32'h0);
        mis("mis ld half 43", 1'b0, SZ_HALF, 32'h43, 32'h0);
        mis("mis st word 46", 1'b1, SZ_WORD, 32'h46, 32'h12345678);
        ld("ld word 44 untouched", SZ_WORD, 1'b0, 32'h44, 32'h0, a1);
`else
        ld("aligned ld word 42", SZ_WORD, 1'b0, 32'h42, 32'h1122AA44, a1);
        ld("aligned ld half 43", SZ_HALF, 1'b0, 32'h43, 32'h00001122, a1);
        st("aligned st word 46", SZ_WORD, 32'h46, 32'h12345678, 32'h12345678, a1);
        ld("ld word 44", SZ_WORD, 1'b0, 32'h44, 32'h12345678, a1);
`endif
        wait_idle();

        // Reset during the RD state of a sub-word store
        st("st word 80", SZ_WORD, 32'h80, 32'h11223344, 32'h11223344, a1);
        wait_idle();
        drive_accept(1'b1, SZ_BYTE, 1'b0, 32'h81, 32'h00000055, a1, ok);
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("abort dram_we_o", {31'd0, dram_we_o}, 32'd0);
        chk("abort req_ready", {31'd0, req_ready}, 32'd1);
        chk("abort resp_valid", {31'd0, resp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort mem unchanged", mem[12'h020], 32'h11223344);
        ld("ld word 80 after abort", SZ_WORD, 1'b0, 32'h80, 32'h11223344, a1);
        wait_idle();

        // Back-to-back with req_valid held high
        ld("b2b ld 40", SZ_WORD, 1'b0, 32'h40, 32'h1122AA44, a1);
        @(negedge clk);
        chk("busy req_ready", {31'd0, req_ready}, 32'd0);
        ld("b2b ld 50", SZ_WORD, 1'b0, 32'h50, 32'hBEEF7FFF, a2);
        chk("b2b load gap", a2 - a1, 32'd4);
        st("b2b st 60", SZ_WORD, 32'h60, 32'hCAFEF00D, 32'hCAFEF00D, a1);
        ld("b2b ld 60", SZ_WORD, 1'b0, 32'h60, 32'hCAFEF00D, a2);
        chk("b2b store gap", a2 - a1, 32'd3);
        wait_idle();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/dram_lsu.md
Name: dram_lsu

Overview:
- Load/store unit directly upstream of the data-memory wrapper.
- Takes byte-addressed load/store requests from the MEM stage and drives the word-wide, single-write-enable data memory (1-cycle synchronous read).
- Performs read-modify-write for byte/halfword stores and sign/zero extension for loads.
- Stalls the pipeline through req_ready.

Parameters:
- ADDR_WIDTH, `ADDR_WIDTH (12): data-memory word-address width.
- WIDTH, `WIDTH (32): data word width.

Ports:
Interface: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle; request accepted when valid&&ready at a rising edge
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- req_unsigned  in  1  load zero-extends when 1
- req_addr  in  32  byte address
- req_wdata  in  WIDTH  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  WIDTH  extended load data (0 for stores)
- resp_err  out  1  misaligned request, qualified by resp_valid
- dram_we_o  out  1  memory write enable
- dram_addr_o  out  ADDR_WIDTH  word address = req_addr[ADDR_WIDTH+1:2]; upper bits ignored (wraps)
- dram_din_o  out  WIDTH  memory write data
- dram_dout_i  in  WIDTH  memory read data, valid one cycle after address

Behaviour:
- Reset values:
  - State IDLE; req_ready=1.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - dram_we_o=0, dram_addr_o=0, dram_din_o=0.
- Request capture: on accept, addr/size/we/unsigned/wdata are registered. req_ready=0 in every state except IDLE. req_valid while busy is ignored.
- FSM states: IDLE, RD, DATA, WR, RESP.
  - Load: IDLE -> RD -> DATA -> RESP -> IDLE.
  - Word store: IDLE -> WR -> RESP -> IDLE.
  - Sub-word store: IDLE -> RD -> DATA -> WR -> RESP -> IDLE.
  - Misaligned request: IDLE -> RESP, with no memory access.
- Per-state outputs:
  - RD: dram_addr_o = word address, dram_we_o=0.
  - DATA: dram_dout_i is captured.
    - Load: the extracted, extended value is registered into resp_rdata.
    - Sub-word store: the merged word is registered into the write buffer.
  - WR: dram_we_o=1 for exactly one cycle, with dram_din_o = merged word (or req_wdata for a word store).
  - RESP: resp_valid=1 for exactly one cycle. There is no backpressure on resp.
- Latency, in cycles from the accept edge to the resp_valid cycle:
  - Load: 3.
  - Word store: 2.
  - Sub-word store: 4.
  - Misaligned: 1.
- Byte/half lanes (little-endian):
  - Byte lane = addr[1:0].
  - Half lane = addr[1] (0 selects bits 15:0).
  - Merge replaces only the addressed lane; other bytes keep the read value.
- Extension: signed loads replicate the MSB of the loaded byte or half; unsigned loads zero-fill.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- dram_we_o is never asserted outside WR.
- Asynchronous reset mid-operation: the FSM returns to IDLE immediately and dram_we_o drops. An interrupted store is discarded with no partial write beyond a WR cycle already completed. No resp_valid is produced for the aborted request.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: misaligned requests are detected as above and complete with resp_err=1, resp_rdata=0, and no memory access.
- Undefined:
  - resp_err is tied 0.
  - Low address bits are forced to alignment: half uses addr[1] only; word ignores addr[1:0].
  - The request proceeds normally.

Decomposition:
- Shared package/header: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state encoding, word-address slice helper constant.
- One natural combinational sub-module, dram_lsu_align, containing:
  - Lane extract plus sign/zero extension for loads.
  - Lane merge for stores.
- The top keeps the FSM and the registers.

Test Plan:
1. Word store then load:
   - Store 0xDEADBEEF to 0x40: dram_we_o pulse with addr 0x010, resp_valid 2 cycles after accept.
   - Load word from 0x40: resp_rdata=0xDEADBEEF 3 cycles after accept.
2. Byte store to 0x41 with wdata 0x000000AA over 0x11223344: RMW writes 0x1122AA44; later signed byte load at 0x41 returns 0xFFFFFFAA, and unsigned returns 0x000000AA.
3. Half loads from word 0x8001_7FFF: signed half at addr[1]=1 returns 0xFFFF8001; signed half at addr[1]=0 returns 0x00007FFF.
4. MISALIGN_TRAP_EN defined: word load at 0x42 gives resp_valid with resp_err=1 and rdata=0 one cycle after accept, with dram_we_o never high. Undefined: the same request reads word 0x010.
5. rst_n asserted during the RD state of a sub-word store: dram_we_o stays 0, memory is unchanged, no resp_valid appears, and req_ready=1 immediately.
6. req_valid held high with back-to-back requests: the second request is accepted only in the cycle after the first request's resp_valid (IDLE), and nothing is accepted while busy.
